// File: rtl/qkv_stream_feeder.sv
// qkv_stream_feeder: reads Q and K/V rows from 1-cycle SRAMs and streams them out, each Q row once then all K/V rows per Q row.

`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 8
`endif

// Two-entry FIFO with registered head/valid so the stream outputs come straight from flops.
module qkv_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [1:0]   o_cnt,
    output logic         o_vld,
    output logic [W-1:0] o_head
);
    logic [1:0]   r_cnt;
    logic         r_vld;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   w_cnt_nxt;

    assign o_cnt  = r_cnt;
    assign o_vld  = r_vld;
    assign o_head = r_head;

    // occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_cnt_nxt = r_cnt + 2'(i_push) - 2'(i_pop);
    end

    // head shifts from tail on pop; incoming data lands in whichever slot is the next free one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_vld  <= 1'b0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_vld <= w_cnt_nxt != 2'd0;
            if (i_pop && r_cnt == 2'd2)
                r_head <= r_tail;
            else if (i_push && (r_cnt == 2'd0 || (i_pop && r_cnt == 2'd1)))
                r_head <= i_din;
            if (i_push && ((r_cnt == 2'd1 && !i_pop) || (r_cnt == 2'd2 && i_pop)))
                r_tail <= i_din;
        end
    end
endmodule

module qkv_stream_feeder #(
    parameter int NUM_Q_ROWS  = `MAX_SEQ_LENGTH,
    parameter int NUM_KV_ROWS = `MAX_SEQ_LENGTH,
    parameter int Q_W         = 16,
    parameter int K_W         = 16,
    parameter int V_W         = 16,
    localparam int QAW        = NUM_Q_ROWS > 1 ? $clog2(NUM_Q_ROWS) : 1,
    localparam int KAW        = NUM_KV_ROWS > 1 ? $clog2(NUM_KV_ROWS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           q_rd_en,
    output logic [QAW-1:0] q_rd_addr,
    input  logic [Q_W-1:0] q_rd_data,
    output logic           kv_rd_en,
    output logic [KAW-1:0] kv_rd_addr,
    input  logic [K_W-1:0] k_rd_data,
    input  logic [V_W-1:0] v_rd_data,
    output logic           Q_vld_out,
    input  logic           Q_rdy_in,
    output logic [Q_W-1:0] q_out,
    output logic           K_vld_out,
    input  logic           K_rdy_in,
    output logic [K_W-1:0] k_out,
    output logic           V_vld_out,
    input  logic           V_rdy_in,
    output logic [V_W-1:0] v_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic [QAW-1:0] r_q_addr;
    logic [QAW-1:0] r_kv_pass;
    logic [KAW-1:0] r_kv_addr;
    logic           r_q_fin;
    logic           r_kv_fin;
    logic           r_q_inf;
    logic           r_kv_inf;
    logic [1:0]     w_q_cnt;
    logic [1:0]     w_k_cnt;
    logic [1:0]     w_v_cnt;
    logic           w_q_pop;
    logic           w_k_pop;
    logic           w_v_pop;
    logic [2:0]     w_q_occ;
    logic [2:0]     w_k_occ;
    logic [2:0]     w_v_occ;
    logic [2:0]     w_kv_occ;
    logic           w_drained;

    assign busy       = r_busy;
    assign done       = r_done;
    assign q_rd_addr  = r_q_addr;
    assign kv_rd_addr = r_kv_addr;

    // occupancy seen by the issue rule: stored entries plus the read in flight, minus this cycle's handshake
    always_comb begin
        w_q_pop   = Q_vld_out && Q_rdy_in;
        w_k_pop   = K_vld_out && K_rdy_in;
        w_v_pop   = V_vld_out && V_rdy_in;
        w_q_occ   = {1'b0, w_q_cnt} + 3'(r_q_inf) - 3'(w_q_pop);
        w_k_occ   = {1'b0, w_k_cnt} + 3'(r_kv_inf) - 3'(w_k_pop);
        w_v_occ   = {1'b0, w_v_cnt} + 3'(r_kv_inf) - 3'(w_v_pop);
        w_kv_occ  = (w_k_occ > w_v_occ) ? w_k_occ : w_v_occ;
        q_rd_en   = (r_state == RUN) && !r_q_fin && (w_q_occ < 3'd2);
        kv_rd_en  = (r_state == RUN) && !r_kv_fin && (w_kv_occ < 3'd2);
        w_drained = r_q_fin && r_kv_fin && (w_q_occ == 3'd0) && (w_k_occ == 3'd0) && (w_v_occ == 3'd0);
    end

    // run control; w_drained looks one cycle ahead so done lands right after the final handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state <= RUN;
                    r_busy  <= 1'b1;
                end
                RUN: if (w_drained) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // read address generators; they park on the last address once every read has been issued
    always_ff @(posedge clk) begin
        if (rst || (r_state == IDLE && start)) begin
            r_q_addr  <= '0;
            r_q_fin   <= 1'b0;
            r_kv_addr <= '0;
            r_kv_pass <= '0;
            r_kv_fin  <= 1'b0;
        end else begin
            if (q_rd_en) begin
                if (r_q_addr == QAW'(NUM_Q_ROWS - 1))
                    r_q_fin <= 1'b1;
                else
                    r_q_addr <= r_q_addr + QAW'(1);
            end
            if (kv_rd_en) begin
                if (r_kv_addr == KAW'(NUM_KV_ROWS - 1)) begin
                    if (r_kv_pass == QAW'(NUM_Q_ROWS - 1))
                        r_kv_fin <= 1'b1;
                    else begin
                        r_kv_addr <= '0;
                        r_kv_pass <= r_kv_pass + QAW'(1);
                    end
                end else
                    r_kv_addr <= r_kv_addr + KAW'(1);
            end
        end
    end

    // in-flight flags mark SRAM data arriving next cycle; clearing them on reset drops stale returns
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_inf  <= 1'b0;
            r_kv_inf <= 1'b0;
        end else begin
            r_q_inf  <= q_rd_en;
            r_kv_inf <= kv_rd_en;
        end
    end

    qkv_fifo2 #(.W(Q_W)) u_q_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_q_inf),
        .i_din  (q_rd_data),
        .i_pop  (w_q_pop),
        .o_cnt  (w_q_cnt),
        .o_vld  (Q_vld_out),
        .o_head (q_out)
    );

    qkv_fifo2 #(.W(K_W)) u_k_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_kv_inf),
        .i_din  (k_rd_data),
        .i_pop  (w_k_pop),
        .o_cnt  (w_k_cnt),
        .o_vld  (K_vld_out),
        .o_head (k_out)
    );

    qkv_fifo2 #(.W(V_W)) u_v_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_kv_inf),
        .i_din  (v_rd_data),
        .i_pop  (w_v_pop),
        .o_cnt  (w_v_cnt),
        .o_vld  (V_vld_out),
        .o_head (v_out)
    );
endmodule

// File: tb/tb_qkv_stream_feeder.sv
// tb_qkv_stream_feeder: directed runs of the Q/K/V feeder with hand-computed beat sequences and timing.
module tb_qkv_stream_feeder;
    localparam int NQ = 2;
    localparam int NKV = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, done, q_rd_en, kv_rd_en;
    logic [0:0] q_rd_addr;
    logic [1:0] kv_rd_addr;
    logic [W-1:0] q_rd_data = '0;
    logic [W-1:0] k_rd_data = '0;
    logic [W-1:0] v_rd_data = '0;
    logic Q_vld_out, K_vld_out, V_vld_out;
    logic Q_rdy_in = 1'b1;
    logic K_rdy_in = 1'b1;
    logic V_rdy_in = 1'b1;
    logic [W-1:0] q_out, k_out, v_out;

    always #5 clk = ~clk;

    qkv_stream_feeder #(.NUM_Q_ROWS(NQ), .NUM_KV_ROWS(NKV), .Q_W(W), .K_W(W), .V_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
        .kv_rd_en(kv_rd_en), .kv_rd_addr(kv_rd_addr), .k_rd_data(k_rd_data), .v_rd_data(v_rd_data),
        .Q_vld_out(Q_vld_out), .Q_rdy_in(Q_rdy_in), .q_out(q_out),
        .K_vld_out(K_vld_out), .K_rdy_in(K_rdy_in), .k_out(k_out),
        .V_vld_out(V_vld_out), .V_rdy_in(V_rdy_in), .v_out(v_out)
    );

    // SRAM models: Q word = 0x20+addr, K word = addr, V word = 0x10+addr
    always @(posedge clk) begin
        if (q_rd_en) q_rd_data <= 8'h20 + 8'(q_rd_addr);
        if (kv_rd_en) begin
            k_rd_data <= 8'(kv_rd_addr);
            v_rd_data <= 8'h10 + 8'(kv_rd_addr);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;
    int t0, q_first, q_last, k_last, v_last, kv_iss, max_k, max_v;
    int n_busy, busy_first, n_done, done_rel, n_viol, kv_at7, snap_q, snap_k, snap_v;
    logic mon = 1'b0;
    logic any_out;
    logic qh, kh, vh;
    logic [W-1:0] qhv, khv, vhv;
    logic [W-1:0] q_seen[$], k_seen[$], v_seen[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mon) begin
            int rel;
            rel = cyc - t0;
            if (Q_vld_out && q_first < 0) q_first = rel;
            if (Q_vld_out && Q_rdy_in) begin q_seen.push_back(q_out); q_last = rel; end
            if (K_vld_out && K_rdy_in) begin k_seen.push_back(k_out); k_last = rel; end
            if (V_vld_out && V_rdy_in) begin v_seen.push_back(v_out); v_last = rel; end
            if (kv_rd_en) kv_iss++;
            if (kv_iss - k_seen.size() > max_k) max_k = kv_iss - k_seen.size();
            if (kv_iss - v_seen.size() > max_v) max_v = kv_iss - v_seen.size();
            if (busy) begin n_busy++; if (busy_first < 0) busy_first = rel; end
            if (done) begin n_done++; done_rel = rel; end
            if (qh && (!Q_vld_out || q_out !== qhv)) n_viol++;
            if (kh && (!K_vld_out || k_out !== khv)) n_viol++;
            if (vh && (!V_vld_out || v_out !== vhv)) n_viol++;
            qh = Q_vld_out && !Q_rdy_in; qhv = q_out;
            kh = K_vld_out && !K_rdy_in; khv = k_out;
            vh = V_vld_out && !V_rdy_in; vhv = v_out;
        end
    end

    task automatic run(input int mode);
        int kblk;
        kblk = 0;
        q_seen.delete(); k_seen.delete(); v_seen.delete();
        q_first = -1; busy_first = -1; q_last = 0; k_last = 0; v_last = 0;
        kv_iss = 0; max_k = 0; max_v = 0; n_busy = 0; n_done = 0; done_rel = 0; n_viol = 0;
        qh = 0; kh = 0; vh = 0; any_out = 0; kv_at7 = 0;
        Q_rdy_in = 1; K_rdy_in = 1; V_rdy_in = (mode != 2);
        @(posedge clk); #1;
        t0 = cyc; mon = 1; start = 1;
        for (int c = 1; c < 200; c++) begin
            @(posedge clk); #1;
            start = 0;
            if (mode == 1) begin
                K_rdy_in = !(k_seen.size() >= 2 && kblk < 5);
                if (!K_rdy_in) kblk++;
            end
            if (mode == 2) V_rdy_in = (c >= 8);
            if (mode == 2 && c == 7) kv_at7 = kv_iss;
            if (mode == 3 && (c == 5 || done)) start = 1;
            if (mode == 4) begin
                if (c == 6) rst = 1;
                if (c == 7) begin
                    rst = 0;
                    snap_q = q_seen.size(); snap_k = k_seen.size(); snap_v = v_seen.size();
                end
                if (c >= 7 && (busy | done | Q_vld_out | K_vld_out | V_vld_out | q_rd_en | kv_rd_en)) any_out = 1;
                if (c == 12) break;
            end
            if (n_done > 0 && c >= done_rel + 3) break;
        end
        mon = 0;
    endtask

    task automatic check_run(input string nm);
        int last;
        chk({nm, "_q_count"}, 32'(q_seen.size()), NQ);
        chk({nm, "_k_count"}, 32'(k_seen.size()), NQ * NKV);
        chk({nm, "_v_count"}, 32'(v_seen.size()), NQ * NKV);
        for (int i = 0; i < NQ; i++)
            chk({nm, "_q_beat"}, 32'(i < q_seen.size() ? q_seen[i] : 8'hFF), 32'h20 + 32'(i));
        for (int i = 0; i < NQ * NKV; i++) begin
            chk({nm, "_k_beat"}, 32'(i < k_seen.size() ? k_seen[i] : 8'hFF), 32'(i % NKV));
            chk({nm, "_v_beat"}, 32'(i < v_seen.size() ? v_seen[i] : 8'hFF), 32'h10 + 32'(i % NKV));
        end
        last = q_last > k_last ? q_last : k_last;
        last = v_last > last ? v_last : last;
        chk({nm, "_done_pulses"}, 32'(n_done), 1);
        chk({nm, "_done_after_last"}, 32'(done_rel), 32'(last + 1));
        chk({nm, "_busy_first"}, 32'(busy_first), 1);
        chk({nm, "_busy_cycles"}, 32'(n_busy), 32'(done_rel - 1));
        chk({nm, "_stable"}, 32'(n_viol), 0);
        chk({nm, "_k_outstanding_le2"}, 32'(max_k <= 2), 1);
        chk({nm, "_v_outstanding_le2"}, 32'(max_v <= 2), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", 32'({busy, done, Q_vld_out, K_vld_out, V_vld_out, q_rd_en, kv_rd_en}), 0);
        chk("rst_addr", 32'({q_rd_addr, kv_rd_addr}), 0);
        chk("rst_data", 32'({q_out, k_out, v_out}), 0);
        rst = 0;

        run(0);
        check_run("ready");
        chk("ready_first_vld", 32'(q_first), 3);
        chk("ready_v_last", 32'(v_last), 10);
        chk("ready_done_cycle", 32'(done_rel), 11);

        run(1);
        check_run("kstall");

        run(2);
        check_run("vstall");
        chk("vstall_kv_reads_held", 32'(kv_at7), 2);
        chk("vstall_done_after_v", 32'(done_rel), 32'(v_last + 1));

        run(3);
        check_run("start_ignored");

        run(4);
        chk("midrst_quiet", 32'(any_out), 0);
        chk("midrst_k_before", 32'(snap_k), 4);
        chk("midrst_q_after", 32'(q_seen.size()), 32'(snap_q));
        chk("midrst_k_after", 32'(k_seen.size()), 32'(snap_k));
        chk("midrst_v_after", 32'(v_seen.size()), 32'(snap_v));

        run(0);
        check_run("replay");
        chk("replay_done_cycle", 32'(done_rel), 11);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
